// File: rtl/vector_result_serializer_pkg.sv
// Shared types and packed-bus helpers for the vector result serializer and
// any future vector (de)serializer working on the same lane layout.
package vector_result_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Each adder sum carries one extra bit over its operands.
  function automatic int elem_width(input int in_width);
    return in_width + 1;
  endfunction

  // LSB position of lane `lane` in a packed bus of `ew`-bit lanes.
  function automatic int lane_lsb(input int lane, input int ew);
    return lane * ew;
  endfunction

endpackage

// File: rtl/vector_result_serializer_bank.sv
// N-element register bank: whole-vector load, full-vector readback and an
// indexed single-element read mux.
module vector_bank_reg
  import vector_result_serializer_pkg::*;
#(
  parameter int N     = 10,
  parameter int EW    = 17,
  parameter int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              load,
  input  logic [N*EW-1:0]   d,
  input  logic [IDX_W-1:0]  idx,
  output logic [N*EW-1:0]   q_all,
  output logic [EW-1:0]     q
);

  logic [N*EW-1:0] mem;

  // NOTE: storage has no reset on purpose; the owner's flags say when it is
  // meaningful. Sequential state is written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (load) mem <= d;
  end

  assign q_all = mem;

  // NOTE: q gets a default before the loop so no latch is inferred when idx
  // points past the last lane.
  always_comb begin
    q = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) q = mem[lane_lsb(k, EW) +: EW];
    end
  end

endmodule

// File: rtl/vector_result_serializer.sv
// Captures one N-element result vector per inReady pulse and replays it one
// element per cycle over a valid/accept stream, with one pending slot.
module vector_result_serializer
  import vector_result_serializer_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int N        = 10,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      inReady,
  input  logic [N*(IN_WIDTH+1)-1:0] sVec,
  input  logic                      dataAccept,
  output logic                      dataValid,
  output logic [IN_WIDTH:0]         dataOut,
  output logic [IDX_W-1:0]          dataIndex,
  output logic                      dataLast,
  output logic                      busy,
  output logic                      pendingFull,
  output logic                      overflow
);

  localparam int EW = elem_width(IN_WIDTH);

  state_t           state;
  logic [IDX_W-1:0] data_index;
  logic             pending_full;
  logic             overflow_q;

  logic             fire;
  logic             last_fire;
  logic             active_load;
  logic             active_from_pending;
  logic             pending_load;
  logic [N*EW-1:0]  active_d;
  logic [N*EW-1:0]  pending_all;
  logic [EW-1:0]    active_elem;
  logic [N*EW-1:0]  unused_active_all;
  logic [EW-1:0]    unused_pending_elem;

  assign busy        = (state == SEND);
  assign dataValid   = busy;
  assign dataIndex   = data_index;
  assign dataLast    = dataValid && (data_index == IDX_W'(N - 1));
  assign pendingFull = pending_full;
  assign overflow    = overflow_q;
  // Bank contents are undefined after reset, so the output is forced to zero when idle.
  assign dataOut     = dataValid ? active_elem : '0;

  assign fire      = dataValid && dataAccept;
  assign last_fire = fire && dataLast;

  // Bank load steering; the sequential control below mirrors these decisions.
  always_comb begin
    active_load         = 1'b0;
    active_from_pending = 1'b0;
    pending_load        = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: active_load = inReady;
        SEND: begin
          if (last_fire) begin
            if (pending_full) begin
              active_load         = 1'b1;
              active_from_pending = 1'b1;
              pending_load        = inReady;
            end else begin
              active_load = inReady;
            end
          end else begin
            pending_load = inReady && !pending_full;
          end
        end
      endcase
    end
  end

  assign active_d = active_from_pending ? pending_all : sVec;

  vector_bank_reg #(.N(N), .EW(EW), .IDX_W(IDX_W)) u_active (
    .clk   (clk),
    .load  (active_load),
    .d     (active_d),
    .idx   (data_index),
    .q_all (unused_active_all),
    .q     (active_elem)
  );

  vector_bank_reg #(.N(N), .EW(EW), .IDX_W(IDX_W)) u_pending (
    .clk   (clk),
    .load  (pending_load),
    .d     (sVec),
    .idx   (data_index),
    .q_all (pending_all),
    .q     (unused_pending_elem)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      data_index   <= '0;
      pending_full <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (inReady) begin
            state      <= SEND;
            data_index <= '0;
          end
        end
        SEND: begin
          if (last_fire) begin
            data_index <= '0;
            if (!pending_full && !inReady) state <= IDLE;
            // A pending vector moves to active; a simultaneous arrival refills pending.
            if (pending_full && !inReady) pending_full <= 1'b0;
          end else begin
            if (fire) data_index <= data_index + 1'b1;
            if (inReady) begin
              if (pending_full) overflow_q   <= 1'b1;
              else              pending_full <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_result_serializer.sv
// Directed, table-driven bench for vector_result_serializer with hand-written
// multi-cycle sequences for back-to-back, overflow and enable corner cases.
module tb_vector_result_serializer;

  localparam int IN_WIDTH = 16;
  localparam int N        = 10;
  localparam int EW       = IN_WIDTH + 1;
  localparam int IDX_W    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b1;
  logic              in_ready = 1'b0;
  logic              data_accept = 1'b0;
  logic [N*EW-1:0]   s_vec = '0;
  logic              data_valid;
  logic [EW-1:0]     data_out;
  logic [IDX_W-1:0]  data_index;
  logic              data_last;
  logic              busy;
  logic              pending_full;
  logic              overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic in_ready;
    logic accept;
    logic exp_valid;
    int   exp_idx;
  } row_t;

  row_t rows[$];

  vector_result_serializer #(.IN_WIDTH(IN_WIDTH), .N(N), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .inReady     (in_ready),
    .sVec        (s_vec),
    .dataAccept  (data_accept),
    .dataValid   (data_valid),
    .dataOut     (data_out),
    .dataIndex   (data_index),
    .dataLast    (data_last),
    .busy        (busy),
    .pendingFull (pending_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [N*EW-1:0] make_vec(input int base, input int stride);
    logic [N*EW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*EW +: EW] = EW'(base + k * stride);
    return v;
  endfunction

  function automatic logic [EW-1:0] elem(input logic [N*EW-1:0] v, input int k);
    return v[k*EW +: EW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string name, input logic [N*EW-1:0] v, input int idx);
    check({name, " valid"}, 32'(data_valid), 32'd1);
    check({name, " out"},   32'(data_out), 32'(elem(v, idx)));
    check({name, " index"}, 32'(data_index), 32'(idx));
    check({name, " last"},  32'(data_last), 32'(idx == N - 1));
  endtask

  initial begin
    logic [N*EW-1:0] va, vx, vy, v1, v2, v3, ve, vf, vg;
    int bp[16];

    va = make_vec(-5, 3);
    vx = make_vec(100, 1);
    vy = make_vec(-200, 7);
    v1 = make_vec(1000, -11);
    v2 = make_vec(-7, 13);
    v3 = make_vec(5, 5);
    ve = make_vec(-65536, 4097);
    vf = make_vec(42, 42);
    vg = make_vec(65535, -3000);

    // Single vector with dataAccept high, then backpressure on beats 2 and 7.
    rows.push_back('{1'b1, 1'b1, 1'b1, 0});
    for (int k = 1; k < N; k++) rows.push_back('{1'b0, 1'b1, 1'b1, k});
    rows.push_back('{1'b0, 1'b1, 1'b0, 0});
    bp = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, 7, 7, 7, 8, 9};
    rows.push_back('{1'b1, 1'b0, 1'b1, 0});
    for (int p = 1; p < 16; p++) rows.push_back('{1'b0, logic'(bp[p] != bp[p-1]), 1'b1, bp[p]});
    rows.push_back('{1'b0, 1'b1, 1'b0, 0});

    // Reset held low while inReady pulses.
    for (int i = 0; i < 3; i++) begin
      in_ready = 1'b1;
      s_vec    = va;
      @(negedge clk);
      check("rst valid",   32'(data_valid), 32'd0);
      check("rst out",     32'(data_out), 32'd0);
      check("rst index",   32'(data_index), 32'd0);
      check("rst last",    32'(data_last), 32'd0);
      check("rst busy",    32'(busy), 32'd0);
      check("rst pending", 32'(pending_full), 32'd0);
      check("rst ovf",     32'(overflow), 32'd0);
    end
    reset    = 1'b1;
    in_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle valid", 32'(data_valid), 32'd0);
    end

    foreach (rows[i]) begin
      in_ready    = rows[i].in_ready;
      data_accept = rows[i].accept;
      s_vec       = va;
      @(negedge clk);
      check($sformatf("row%0d valid", i), 32'(data_valid), 32'(rows[i].exp_valid));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(rows[i].exp_valid));
      if (rows[i].exp_valid) check_beat($sformatf("row%0d", i), va, rows[i].exp_idx);
    end
    in_ready = 1'b0;

    // Back-to-back: Y arrives four cycles after X, drains with no bubble.
    data_accept = 1'b1;
    in_ready    = 1'b1;
    s_vec       = vx;
    @(negedge clk);
    for (int b = 0; b < 2 * N; b++) begin
      check_beat($sformatf("b2b%0d", b), (b < N) ? vx : vy, b % N);
      check($sformatf("b2b%0d pending", b), 32'(pending_full), 32'(b >= 4 && b < N));
      in_ready = (b == 3);
      s_vec    = vy;
      @(negedge clk);
    end
    check("b2b end valid", 32'(data_valid), 32'd0);

    // Overflow: third vector dropped while the consumer stalls.
    data_accept = 1'b0;
    in_ready    = 1'b1;
    s_vec       = v1;
    @(negedge clk);
    check_beat("ovf t", v1, 0);
    in_ready = 1'b0;
    @(negedge clk);
    in_ready = 1'b1;
    s_vec    = v2;
    @(negedge clk);
    check("ovf pending", 32'(pending_full), 32'd1);
    check("ovf early",   32'(overflow), 32'd0);
    in_ready = 1'b0;
    @(negedge clk);
    in_ready = 1'b1;
    s_vec    = v3;
    @(negedge clk);
    check("ovf set", 32'(overflow), 32'd1);
    in_ready    = 1'b0;
    data_accept = 1'b1;
    for (int b = 0; b < 2 * N; b++) begin
      check_beat($sformatf("ovf drain%0d", b), (b < N) ? v1 : v2, b % N);
      @(negedge clk);
    end
    check("ovf drained valid", 32'(data_valid), 32'd0);
    check("ovf sticky",        32'(overflow), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("ovf cleared", 32'(overflow), 32'd0);
    reset = 1'b1;

    // Enable low mid-drain: nothing moves, nothing is captured.
    in_ready = 1'b1;
    s_vec    = ve;
    @(negedge clk);
    in_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_beat("en pre", ve, 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_ready = (i % 2 == 0);
      s_vec    = vf;
      @(negedge clk);
      check_beat($sformatf("en hold%0d", i), ve, 3);
      check($sformatf("en hold%0d pending", i), 32'(pending_full), 32'd0);
    end
    enable   = 1'b1;
    in_ready = 1'b0;
    for (int k = 4; k < N; k++) begin
      @(negedge clk);
      check_beat($sformatf("en post%0d", k), ve, k);
    end

    // New vector coincident with the last accepted beat and an empty pending slot.
    in_ready = 1'b1;
    s_vec    = vg;
    @(negedge clk);
    check_beat("coinc0", vg, 0);
    check("coinc pending", 32'(pending_full), 32'd0);
    in_ready = 1'b0;
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      check_beat($sformatf("coinc%0d", k), vg, k);
    end
    @(negedge clk);
    check("coinc end valid", 32'(data_valid), 32'd0);

    // inReady while disabled in IDLE is ignored.
    enable   = 1'b0;
    in_ready = 1'b1;
    s_vec    = vf;
    @(negedge clk);
    check("idle dis valid", 32'(data_valid), 32'd0);
    enable   = 1'b1;
    in_ready = 1'b0;
    @(negedge clk);
    check("idle dis after", 32'(data_valid), 32'd0);
    check("idle dis ovf",   32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
